// File: rtl/mp2_l1_cache_pkg.sv
// Shared types and helpers for the mp2 L1 cache: line geometry, FSM state
// encoding and the byte-lane word merge used by write hits.
package cache_types;

    localparam int OFFSET_W = 5;
    localparam int LINE_W   = 256;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    // Replace the enabled bytes of one 32-bit word inside a cache line.
    function automatic logic [LINE_W-1:0] word_merge(
        input logic [LINE_W-1:0] line,
        input logic [2:0]        word_idx,
        input logic [31:0]       wdata,
        input logic [3:0]        be
    );
        logic [LINE_W-1:0] merged;
        merged = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[int'(word_idx) * 32 + b * 8 +: 8] = wdata[b * 8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mp2_l1_cache_array.sv
// Per-set storage for the L1 cache: valid/dirty/tag plus a 256-bit line kept
// as 32 independent byte lanes so a write can touch any subset of bytes.
module cache_array
    import cache_types::*;
#(
    parameter int S_INDEX = 3,
    parameter int TAG_W   = 32 - OFFSET_W - S_INDEX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [S_INDEX-1:0]  i_index,
    input  logic [31:0]         i_byte_we,
    input  logic [LINE_W-1:0]   i_wline,
    input  logic                i_meta_we,
    input  logic [TAG_W-1:0]    i_wtag,
    input  logic                i_dirty_we,
    input  logic                i_dirty_val,
    output logic                o_valid,
    output logic                o_dirty,
    output logic [TAG_W-1:0]    o_tag,
    output logic [LINE_W-1:0]   o_line
);

    localparam int SETS = 2 ** S_INDEX;

    logic [SETS-1:0]  r_valid;
    logic [SETS-1:0]  r_dirty;
    logic [TAG_W-1:0] r_tag [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_meta_we) begin
                r_valid[i_index] <= 1'b1;
            end
            if (i_dirty_we) begin
                r_dirty[i_index] <= i_dirty_val;
            end
        end
    end

    // Tags carry no reset: a stale tag is harmless while its valid bit is clear.
    always_ff @(posedge clk) begin
        if (i_meta_we) begin
            r_tag[i_index] <= i_wtag;
        end
    end

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_lane
            logic [7:0] r_lane [SETS];

            always_ff @(posedge clk) begin
                if (i_byte_we[gi]) begin
                    r_lane[i_index] <= i_wline[gi * 8 +: 8];
                end
            end

            assign o_line[gi * 8 +: 8] = r_lane[i_index];
        end
    endgenerate

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];

endmodule

// File: rtl/mp2_l1_cache.sv
// Direct-mapped write-back/write-allocate L1 between the RV32I core and
// 256-bit physical memory. Optional hit/miss counters: define CACHE_STATS_EN.
module mp2_l1_cache
    import cache_types::*;
#(
    parameter  int S_INDEX = 3,
    localparam int TAG_W   = 32 - OFFSET_W - S_INDEX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [3:0]          mem_byte_enable,
    input  logic [31:0]         mem_address,
    input  logic [31:0]         mem_wdata,
    output logic                mem_resp,
    output logic [31:0]         mem_rdata,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [31:0]         pmem_address,
    output logic [LINE_W-1:0]   pmem_wdata,
    input  logic [LINE_W-1:0]   pmem_rdata,
    input  logic                pmem_resp
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);

    state_t r_state;
    state_t w_state_next;

    logic [S_INDEX-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic [2:0]         w_word;
    logic               w_unused_addr;

    logic               w_valid;
    logic               w_dirty;
    logic [TAG_W-1:0]   w_tag_rd;
    logic [LINE_W-1:0]  w_line;
    logic               w_hit;

    logic [31:0]        w_byte_we;
    logic [LINE_W-1:0]  w_wline;
    logic               w_meta_we;
    logic               w_dirty_we;
    logic               w_dirty_val;

    assign w_index       = mem_address[OFFSET_W + S_INDEX - 1 : OFFSET_W];
    assign w_tag         = mem_address[31 : OFFSET_W + S_INDEX];
    assign w_word        = mem_address[4:2];
    assign w_unused_addr = &{1'b0, mem_address[1:0]};

    cache_array #(
        .S_INDEX (S_INDEX),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_index     (w_index),
        .i_byte_we   (w_byte_we),
        .i_wline     (w_wline),
        .i_meta_we   (w_meta_we),
        .i_wtag      (w_tag),
        .i_dirty_we  (w_dirty_we),
        .i_dirty_val (w_dirty_val),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tag       (w_tag_rd),
        .o_line      (w_line)
    );

    assign w_hit = w_valid && (w_tag_rd == w_tag);

    always_comb begin
        w_state_next = r_state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {w_tag, w_index, {OFFSET_W{1'b0}}};
        w_byte_we    = '0;
        w_wline      = pmem_rdata;
        w_meta_we    = 1'b0;
        w_dirty_we   = 1'b0;
        w_dirty_val  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                if (w_hit) begin
                    mem_resp     = 1'b1;
                    w_state_next = IDLE;
                    // A write wins over a simultaneous (illegal) read.
                    if (mem_write) begin
                        w_byte_we   = 32'(mem_byte_enable) << {w_word, 2'b00};
                        w_wline     = word_merge(w_line, w_word, mem_wdata, mem_byte_enable);
                        w_dirty_we  = 1'b1;
                        w_dirty_val = 1'b1;
                    end
                end else begin
                    w_state_next = w_dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {w_tag_rd, w_index, {OFFSET_W{1'b0}}};
                if (pmem_resp) begin
                    w_dirty_we   = 1'b1;
                    w_state_next = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    w_byte_we    = '1;
                    w_meta_we    = 1'b1;
                    w_dirty_we   = 1'b1;
                    w_state_next = CHECK;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign mem_rdata  = mem_resp ? w_line[{w_word, 5'b00000} +: 32] : 32'd0;
    assign pmem_wdata = w_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic        r_after_fill;

    // The hit that follows a fill completes the original miss; it is not a new hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_after_fill <= 1'b0;
        end else begin
            if (r_state == FILL && pmem_resp) begin
                r_after_fill <= 1'b1;
            end else if (r_state == CHECK) begin
                r_after_fill <= 1'b0;
            end
            if (r_state == CHECK) begin
                if (!w_hit) begin
                    r_miss_count <= r_miss_count + 32'd1;
                end else if (!r_after_fill) begin
                    r_hit_count <= r_hit_count + 32'd1;
                end
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

`ifndef SYNTHESIS
    a_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));
`endif

endmodule
